// File: rtl/uart_asm_pkg.sv
// uart_asm_pkg
//   Shared constants, helper function and types for the UART word assembler.
//   BYTE_W       : width of one received byte
//   clog2()      : ceiling log2, used for counter and pointer widths
//   byte_order_e : where the first received byte lands within a word
package uart_asm_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ORDER_MSB_FIRST = 1'b0,
    ORDER_LSB_FIRST = 1'b1
  } byte_order_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < longint'(v)) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// word_fifo
//   Show-ahead FIFO with power-of-two depth. The read and write pointers
//   carry one extra wrap bit so full and empty can be told apart.
//   Storage resets to zero, so rdata_o never shows X.
//   Ports:
//     clk_i, rst_ni    : clock, asynchronous active-low reset
//     push_i, wdata_i  : write request and data (ignored when full without pop)
//     pop_i            : read request (ignored when empty)
//     rdata_o          : head entry
//     full_o, empty_o  : occupancy flags
module word_fifo
  import uart_asm_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // is accepted whenever it coincides with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// uart_word_assembler
//   Packs WORD_BYTES received bytes into one word (byte order chosen by
//   MSB_FIRST) and queues finished words in a FIFO_DEPTH-entry show-ahead
//   FIFO drained by a valid/ready handshake. A finished word that finds the
//   FIFO full (and no pop that cycle) is dropped and sets sticky overflow.
//   Optional feature macro: UART_ASM_TIMEOUT_EN -- discards a partial word
//   after TIMEOUT_CYCLES idle cycles and adds the timeout_pulse output.
//   Ports:
//     iCE_CLK, rst_n        : clock, asynchronous active-low reset
//     rx_valid, rx_byte     : received byte strobe and data
//     flush                 : discard the partial word (and any byte this cycle)
//     word_data, word_valid : FIFO head word and non-empty flag
//     word_ready            : consumer accepts the head word
//     byte_count            : bytes held in the partial word
//     overflow, overflow_clr: sticky drop flag and its clear (set wins)
//     timeout_pulse         : one-cycle timeout indication (macro only)
module uart_word_assembler
  import uart_asm_pkg::*;
#(
  parameter int unsigned WORD_BYTES     = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned MSB_FIRST      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                            iCE_CLK,
  input  logic                            rst_n,
  input  logic                            rx_valid,
  input  logic [7:0]                      rx_byte,
  input  logic                            flush,
  output logic [BYTE_W*WORD_BYTES-1:0]    word_data,
  output logic                            word_valid,
  input  logic                            word_ready,
  output logic [clog2(WORD_BYTES)-1:0]    byte_count,
  output logic                            overflow,
  input  logic                            overflow_clr
`ifdef UART_ASM_TIMEOUT_EN
  ,
  output logic                            timeout_pulse
`endif
);

  localparam int unsigned CW = clog2(WORD_BYTES);
  localparam int unsigned WW = BYTE_W * WORD_BYTES;
  localparam byte_order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] part_q, part_d, word_next;
  logic          overflow_q, overflow_d;
  logic          fifo_full, fifo_empty;
  logic          take, complete, pop, push, discard, timeout_hit;

`ifdef UART_ASM_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        pulse_q;

  // Fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES.
  assign timeout_hit = (count_q != '0) && !rx_valid &&
                       (idle_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = idle_q;
    if (rx_valid || (count_q == '0) || timeout_hit) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 32'd1;
    end
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      idle_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      pulse_q <= timeout_hit;
    end
  end

  assign timeout_pulse = pulse_q;
`else
  assign timeout_hit = 1'b0;
`endif

  assign discard = flush || timeout_hit;

  always_comb begin
    word_next = part_q;
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      int unsigned pos;
      pos = (ORDER == ORDER_MSB_FIRST) ? (WORD_BYTES - 1 - k) : k;
      if (count_q == CW'(k)) begin
        word_next[pos*BYTE_W +: BYTE_W] = rx_byte;
      end
    end

    take     = rx_valid && !discard;
    complete = take && (count_q == CW'(WORD_BYTES - 1));
    pop      = !fifo_empty && word_ready;
    push     = complete && (!fifo_full || pop);

    count_d = count_q;
    part_d  = part_q;
    // A dropped word still restarts the count so later words stay aligned.
    if (discard || complete) begin
      count_d = '0;
      part_d  = '0;
    end else if (take) begin
      count_d = count_q + CW'(1);
      part_d  = word_next;
    end

    overflow_d = overflow_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (complete && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      part_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      part_q     <= part_d;
      overflow_q <= overflow_d;
    end
  end

  word_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iCE_CLK),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (word_next),
    .pop_i   (pop),
    .rdata_o (word_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign word_valid = !fifo_empty;
  assign byte_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler: a 2-byte MSB-first instance with a
// 4-entry FIFO, and a 4-byte LSB-first instance.
module tb_uart_word_assembler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WORD_BYTES=2, MSB_FIRST=1, FIFO_DEPTH=4, TIMEOUT_CYCLES=10
  logic        a_rx_valid = 1'b0;
  logic [7:0]  a_rx_byte = '0;
  logic        a_flush = 1'b0;
  logic [15:0] a_word_data;
  logic        a_word_valid;
  logic        a_word_ready = 1'b0;
  logic [0:0]  a_byte_count;
  logic        a_overflow;
  logic        a_overflow_clr = 1'b0;
`ifdef UART_ASM_TIMEOUT_EN
  logic        a_timeout_pulse;
  logic        b_timeout_pulse;
`endif

  // Instance B: WORD_BYTES=4, MSB_FIRST=0
  logic        b_rx_valid = 1'b0;
  logic [7:0]  b_rx_byte = '0;
  logic [31:0] b_word_data;
  logic        b_word_valid;
  logic        b_word_ready = 1'b0;
  logic [1:0]  b_byte_count;
  logic        b_overflow;

  int errors = 0;
  int checks = 0;

  uart_word_assembler #(
    .WORD_BYTES     (2),
    .FIFO_DEPTH     (4),
    .MSB_FIRST      (1),
    .TIMEOUT_CYCLES (10)
  ) dut_a (
    .iCE_CLK      (clk),
    .rst_n        (rst_n),
    .rx_valid     (a_rx_valid),
    .rx_byte      (a_rx_byte),
    .flush        (a_flush),
    .word_data    (a_word_data),
    .word_valid   (a_word_valid),
    .word_ready   (a_word_ready),
    .byte_count   (a_byte_count),
    .overflow     (a_overflow),
    .overflow_clr (a_overflow_clr)
`ifdef UART_ASM_TIMEOUT_EN
    ,
    .timeout_pulse(a_timeout_pulse)
`endif
  );

  uart_word_assembler #(
    .WORD_BYTES (4),
    .FIFO_DEPTH (4),
    .MSB_FIRST  (0)
  ) dut_b (
    .iCE_CLK      (clk),
    .rst_n        (rst_n),
    .rx_valid     (b_rx_valid),
    .rx_byte      (b_rx_byte),
    .flush        (1'b0),
    .word_data    (b_word_data),
    .word_valid   (b_word_valid),
    .word_ready   (b_word_ready),
    .byte_count   (b_byte_count),
    .overflow     (b_overflow),
    .overflow_clr (1'b0)
`ifdef UART_ASM_TIMEOUT_EN
    ,
    .timeout_pulse(b_timeout_pulse)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    a_rx_valid = 1'b1;
    a_rx_byte  = b;
    tick();
    a_rx_valid = 1'b0;
  endtask

  task automatic send_word_a(input logic [15:0] w);
    send_a(w[15:8]);
    send_a(w[7:0]);
  endtask

  task automatic send_b(input logic [7:0] b);
    b_rx_valid = 1'b1;
    b_rx_byte  = b;
    tick();
    b_rx_valid = 1'b0;
  endtask

  task automatic pop_a(input string tag, input logic [15:0] exp);
    check({tag, "_valid"}, 32'(a_word_valid), 32'd1);
    check({tag, "_data"}, 32'(a_word_data), 32'(exp));
    a_word_ready = 1'b1;
    tick();
    a_word_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] words [4];
    words[0] = 16'h0102; words[1] = 16'h0304;
    words[2] = 16'h0506; words[3] = 16'h0708;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(a_word_valid), 32'd0);
    check("rst_data", 32'(a_word_data), 32'd0);
    check("rst_count", 32'(a_byte_count), 32'd0);
    check("rst_ovf", 32'(a_overflow), 32'd0);
    check("rst_b_data", b_word_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // MSB-first assembly, latency 1, pop empties the FIFO
    send_a(8'hAB);
    check("ab_count", 32'(a_byte_count), 32'd1);
    check("ab_valid", 32'(a_word_valid), 32'd0);
    send_a(8'hCD);
    check("abcd_count", 32'(a_byte_count), 32'd0);
    pop_a("abcd", 16'hABCD);
    check("abcd_empty", 32'(a_word_valid), 32'd0);

    // LSB-first, 4 bytes per word
    send_b(8'h11);
    send_b(8'h22);
    send_b(8'h33);
    check("b_count3", 32'(b_byte_count), 32'd3);
    check("b_valid_early", 32'(b_word_valid), 32'd0);
    send_b(8'h44);
    check("b_valid", 32'(b_word_valid), 32'd1);
    check("b_data", b_word_data, 32'h44332211);
    check("b_count0", 32'(b_byte_count), 32'd0);

    // Flush mid-word; byte arriving with flush is discarded too
    send_a(8'h12);
    a_flush = 1'b1;
    send_a(8'h99);
    a_flush = 1'b0;
    check("flush_count", 32'(a_byte_count), 32'd0);
    check("flush_valid", 32'(a_word_valid), 32'd0);
    send_a(8'h34);
    send_a(8'h56);
    pop_a("flush_word", 16'h3456);
    check("flush_empty", 32'(a_word_valid), 32'd0);

    // Overflow: 5 words into a 4-deep FIFO with no consumer
    for (int i = 0; i < 4; i++) send_word_a(words[i]);
    check("full_no_ovf", 32'(a_overflow), 32'd0);
    send_word_a(16'h090A);
    check("ovf_set", 32'(a_overflow), 32'd1);
    check("ovf_count", 32'(a_byte_count), 32'd0);
    for (int i = 0; i < 4; i++) pop_a($sformatf("ovf_pop%0d", i), words[i]);
    check("ovf_empty", 32'(a_word_valid), 32'd0);
    check("ovf_sticky", 32'(a_overflow), 32'd1);
    a_overflow_clr = 1'b1;
    tick();
    a_overflow_clr = 1'b0;
    check("ovf_clr", 32'(a_overflow), 32'd0);

    // Full FIFO with completing byte and pop in the same cycle
    send_word_a(16'h1111);
    send_word_a(16'h2222);
    send_word_a(16'h3333);
    send_word_a(16'h4444);
    send_a(8'h55);
    a_rx_valid   = 1'b1;
    a_rx_byte    = 8'h66;
    a_word_ready = 1'b1;
    tick();
    a_rx_valid   = 1'b0;
    a_word_ready = 1'b0;
    check("fp_no_ovf", 32'(a_overflow), 32'd0);
    pop_a("fp0", 16'h2222);
    pop_a("fp1", 16'h3333);
    pop_a("fp2", 16'h4444);
    pop_a("fp3", 16'h5566);
    check("fp_empty", 32'(a_word_valid), 32'd0);

    // Overflow set and clear in the same cycle: set wins
    for (int i = 0; i < 4; i++) send_word_a(words[i]);
    send_a(8'hEE);
    a_overflow_clr = 1'b1;
    send_a(8'hFF);
    a_overflow_clr = 1'b0;
    check("setwins_ovf", 32'(a_overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_a($sformatf("sw_pop%0d", i), words[i]);

    // Asynchronous reset mid-word with a word queued
    send_word_a(16'hAAAA);
    send_a(8'h77);
    check("prerst_count", 32'(a_byte_count), 32'd1);
    check("prerst_valid", 32'(a_word_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(a_word_valid), 32'd0);
    check("arst_count", 32'(a_byte_count), 32'd0);
    check("arst_data", 32'(a_word_data), 32'd0);
    check("arst_ovf", 32'(a_overflow), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();

`ifdef UART_ASM_TIMEOUT_EN
    // Timeout after 10 idle cycles discards the partial word
    send_a(8'h01);
    repeat (9) tick();
    check("to_pre_pulse", 32'(a_timeout_pulse), 32'd0);
    check("to_pre_count", 32'(a_byte_count), 32'd1);
    tick();
    check("to_pulse", 32'(a_timeout_pulse), 32'd1);
    check("to_count", 32'(a_byte_count), 32'd0);
    tick();
    check("to_pulse_end", 32'(a_timeout_pulse), 32'd0);
    check("to_valid", 32'(a_word_valid), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
# uart_word_assembler

Parametrised byte-to-word deserializer between the UART receiver and the RSA datapath. It packs `WORD_BYTES` consecutive received bytes into one word, in a selectable byte order, and queues completed words in a small FIFO. The FIFO drains through a valid/ready handshake, so the downstream consumer may stall. Overflow is reported instead of being silently lost.

## Interface
Parameters:
- `WORD_BYTES`, default 2: bytes per word; at least 2.
- `FIFO_DEPTH`, default 4: output word FIFO entries; a power of two, at least 2.
- `MSB_FIRST`, default 1: 1 means the first received byte lands in the top byte of the word; 0 means it lands in bits [7:0].
- `TIMEOUT_CYCLES`, default 65535: idle cycles before a partial word is discarded; used only with `UART_ASM_TIMEOUT_EN`.

Ports:
- `iCE_CLK`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `rx_valid`  in  1  one-cycle strobe: `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `flush`  in  1  discard the partial word; FIFO contents are kept.
- `word_data`  out  8*WORD_BYTES  head-of-FIFO word.
- `word_valid`  out  1  FIFO is non-empty.
- `word_ready`  in  1  consumer accepts the head word.
- `byte_count`  out  clog2(WORD_BYTES)  bytes held in the partial word.
- `overflow`  out  1  sticky; a completed word was dropped.
- `overflow_clr`  in  1  clears `overflow`.

## Operation
Reset values: all outputs are 0, the FIFO is empty, and the partial word is cleared.

Assembly:
- Each cycle with `rx_valid`=1 stores `rx_byte` at slot `byte_count` and increments `byte_count`.
- Slot k occupies bits [8(WORD_BYTES-1-k)+7 : 8(WORD_BYTES-1-k)] when `MSB_FIRST`=1, and bits [8k+7:8k] when `MSB_FIRST`=0.

Completion:
- On the byte that brings the count to `WORD_BYTES`, the full word is pushed to the FIFO and `byte_count` wraps to 0.

FIFO:
- Show-ahead: `word_data` is the head entry whenever `word_valid`=1.
- A pop occurs when `word_valid` and `word_ready` are both 1.
- With the FIFO full and a pop in the same cycle, the push succeeds.
- With the FIFO full and no pop, the completed word is dropped, `overflow` is set, and `byte_count` still wraps to 0 so word alignment is preserved.

Flush:
- `flush`=1 forces `byte_count` to 0 and clears the partial word.
- If `rx_valid` is also 1, the incoming byte is discarded as well.

Overflow clear:
- `overflow_clr` and a new overflow in the same cycle: set wins.

`word_data` is X-free: unwritten FIFO entries read 0.

## Timing
- Completing byte sampled at edge N: `word_valid` is 1 after edge N when the FIFO was empty. The push is visible in the cycle after the byte strobe, a latency of 1.
- Pop at edge M: the next entry, or `word_valid`=0, appears after edge M.
- Back-to-back `rx_valid` on every cycle is supported; throughput is 1 byte per cycle.
- Asserting `rst_n` low mid-word or mid-drain clears everything immediately, without waiting for a clock edge.

## Configuration
Macro `UART_ASM_TIMEOUT_EN`.

Defined:
- An idle counter resets on every `rx_valid` and counts cycles while `byte_count`≠0.
- On reaching `TIMEOUT_CYCLES`, the block behaves exactly as a `flush` and the counter stops.
- An extra 1-bit output `timeout_pulse` pulses for one cycle at each timeout.

Undefined:
- No counter and no `timeout_pulse` port.
- A partial word waits indefinitely.

## Structure
Package `uart_asm_pkg`:
- Constant `BYTE_W`=8.
- Function `clog2`.
- Typedef for the byte-order enum (`ORDER_MSB_FIRST`, `ORDER_LSB_FIRST`).

Sub-module `word_fifo`:
- Parametrised by width and depth.
- Signals: push/pop/full/empty, power-of-two pointers with one extra wrap bit.
- Instantiated once.

## Test plan
- **MSB_FIRST, WORD_BYTES=2:** bytes 0xAB, 0xCD, then `word_ready`=1 -> `word_data`=0xABCD and `word_valid`=1 one cycle after 0xCD; pop leaves the FIFO empty.
- **MSB_FIRST=0, WORD_BYTES=4:** bytes 0x11, 0x22, 0x33, 0x44 -> `word_data`=0x44332211.
- **FIFO_DEPTH=4, `word_ready`=0:** send 5 words -> first 4 retained in order, 5th dropped, `overflow`=1, `byte_count`=0. `overflow_clr` -> `overflow`=0.
- **Flush mid-word:** byte 0x12, `flush`, then 0x34, 0x56 -> single word 0x3456.
- **Full plus simultaneous pop:** with the FIFO full, the completing byte and a pop land in the same cycle -> no overflow, FIFO remains full.
- **Reset mid-word and timeout:** `rst_n` low after 1 byte -> all outputs 0. With `UART_ASM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10, one byte then 10 idle cycles -> `timeout_pulse` pulses and `byte_count`=0.
